// File: rtl/io_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_input_ctrl
// Description : Memory-mapped input peripheral for the core's IO space.
//               Per channel: 2-flop synchroniser, counter debouncer, sticky
//               W1C rise/fall capture and a maskable level interrupt.
//               Word map: 0 STATE (RO), 1 RISE (W1C), 2 FALL (W1C), 3 IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_ctrl #(
    parameter int NUM_CH    = 32,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_raw,
    input  logic [1:0]        i_addr,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_irq
);

    localparam logic [1:0]       c_addr_state  = 2'd0;
    localparam logic [1:0]       c_addr_rise   = 2'd1;
    localparam logic [1:0]       c_addr_fall   = 2'd2;
    localparam logic [1:0]       c_addr_irq_en = 2'd3;
    localparam logic [CNT_W-1:0] c_db_last     = CNT_W'(DB_CYCLES - 1);

    logic [NUM_CH-1:0] r_s1;
    logic [NUM_CH-1:0] r_s2;
    logic [NUM_CH-1:0] r_db;
    logic [NUM_CH-1:0] r_rise;
    logic [NUM_CH-1:0] r_fall;
    logic [NUM_CH-1:0] r_irq_en;

    logic [NUM_CH-1:0] w_db_load;
    logic [NUM_CH-1:0] w_rise_set;
    logic [NUM_CH-1:0] w_fall_set;
    logic [NUM_CH-1:0] w_rise_clr;
    logic [NUM_CH-1:0] w_fall_clr;
    logic [NUM_CH-1:0] w_rise_next;
    logic [NUM_CH-1:0] w_fall_next;
    logic [NUM_CH-1:0] w_irq_en_next;
    logic [31:0]       w_rd_sel;

    // Per-channel debounce counter; w_db_load marks the cycle a new level is accepted
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;

            assign w_db_load[gi] = (r_s2[gi] != r_db[gi]) && (r_cnt == c_db_last);

            // Count consecutive mismatching cycles; any agreement restarts the count
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (r_s2[gi] == r_db[gi]) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Two-flop synchroniser and debounced level register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_db <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            r_db <= (r_db & ~w_db_load) | (r_s2 & w_db_load);
        end
    end

    // Next-state for edge flags and enable; a set in the same cycle beats a W1C clear
    always_comb begin
        w_rise_set    = w_db_load & r_s2;
        w_fall_set    = w_db_load & ~r_s2;
        w_rise_clr    = '0;
        w_fall_clr    = '0;
        w_irq_en_next = r_irq_en;
        if (i_wr && (i_addr == c_addr_rise)) begin
            w_rise_clr = i_wdata[NUM_CH-1:0];
        end
        if (i_wr && (i_addr == c_addr_fall)) begin
            w_fall_clr = i_wdata[NUM_CH-1:0];
        end
        if (i_wr && (i_addr == c_addr_irq_en)) begin
            w_irq_en_next = i_wdata[NUM_CH-1:0];
        end
        w_rise_next = (r_rise & ~w_rise_clr) | w_rise_set;
        w_fall_next = (r_fall & ~w_fall_clr) | w_fall_set;
    end

    // Read mux over current (pre-write) register values, zero-extended to 32 bits
    always_comb begin
        w_rd_sel = '0;
        case (i_addr)
            c_addr_state:  w_rd_sel[NUM_CH-1:0] = r_db;
            c_addr_rise:   w_rd_sel[NUM_CH-1:0] = r_rise;
            c_addr_fall:   w_rd_sel[NUM_CH-1:0] = r_fall;
            c_addr_irq_en: w_rd_sel[NUM_CH-1:0] = r_irq_en;
            default:       w_rd_sel = '0;
        endcase
    end

    // Flag, enable, read-data and interrupt registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rise   <= '0;
            r_fall   <= '0;
            r_irq_en <= '0;
            o_rdata  <= '0;
            o_irq    <= 1'b0;
        end else begin
            r_rise   <= w_rise_next;
            r_fall   <= w_fall_next;
            r_irq_en <= w_irq_en_next;
            if (i_rd) begin
                o_rdata <= w_rd_sel;
            end
            // Uses next-state values so the interrupt tracks the flags edge-for-edge
            o_irq <= |((w_rise_next | w_fall_next) & w_irq_en_next);
        end
    end

endmodule
`default_nettype wire
